// File: rtl/palette_pkg.sv
// ============================================================================
// Module   : palette_pkg
// Purpose  : Shared colour types, defaults and width helpers for the palette LUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

package palette_pkg;

    localparam int COLOR_W_DEF = 4;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '0;

    // A single-bank build still needs a 1-bit select port.
    function automatic int bank_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/palette_fade_scaler.sv
// ============================================================================
// Module   : palette_fade_scaler
// Purpose  : One registered colour-channel scale stage: (c * (brightness+1)) >> 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module palette_fade_scaler #(
    parameter int COLOR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] c_i,
    input  logic [3:0]         brightness_i,
    output logic [COLOR_W-1:0] c_o
);

    logic [4:0]         w_gain;
    logic [COLOR_W+3:0] w_prod;

    // Gain tops out at 16, so the product never needs more than COLOR_W+4 bits.
    assign w_gain = {1'b0, brightness_i} + 5'd1;
    assign w_prod = (COLOR_W + 4)'(c_i) * (COLOR_W + 4)'(w_gain);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_o <= '0;
        end else begin
            c_o <= COLOR_W'(w_prod >> 4);
        end
    end

endmodule

`default_nettype wire

// File: rtl/banked_palette_lut.sv
// ============================================================================
// Module   : banked_palette_lut
// Purpose  : Runtime-writable multi-bank colour LUT with frame-synchronous bank
//            swap. Optional macro PALETTE_FADE_EN adds a brightness fade stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module banked_palette_lut
    import palette_pkg::*;
#(
    parameter  int INDEX_W   = 4,
    parameter  int COLOR_W   = COLOR_W_DEF,
    parameter  int NUM_BANKS = 4,
    localparam int BANK_W    = bank_w(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid_i,
    input  logic [INDEX_W-1:0]   index_i,
    input  logic                 wr_en_i,
    input  logic [BANK_W-1:0]    wr_bank_i,
    input  logic [INDEX_W-1:0]   wr_index_i,
    input  logic [3*COLOR_W-1:0] wr_rgb_i,
    input  logic                 bank_sel_we_i,
    input  logic [BANK_W-1:0]    bank_sel_i,
    input  logic                 frame_start_i,
`ifdef PALETTE_FADE_EN
    input  logic [3:0]           brightness_i,
`endif
    output logic                 pix_valid_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic [BANK_W-1:0]    active_bank_o
);

    localparam int              ENTRIES     = 2 ** INDEX_W;
    localparam logic [BANK_W:0] C_NUM_BANKS = (BANK_W + 1)'(NUM_BANKS);

    rgb_t              r_table [NUM_BANKS][ENTRIES];
    logic [BANK_W-1:0] r_staged;
    logic [BANK_W-1:0] r_active;
    rgb_t              r_rgb;
    logic              r_valid;

    logic w_wr_ok;
    logic w_sel_ok;
    logic w_hit;
    rgb_t w_wr_rgb;
    rgb_t w_lookup;

    assign w_wr_ok  = ({1'b0, wr_bank_i}  < C_NUM_BANKS);
    assign w_sel_ok = ({1'b0, bank_sel_i} < C_NUM_BANKS);
    assign w_wr_rgb = wr_rgb_i;

    // Same-cycle write to the entry being looked up bypasses the table.
    assign w_hit    = wr_en_i && w_wr_ok && (wr_bank_i == r_active) && (wr_index_i == index_i);
    assign w_lookup = w_hit ? w_wr_rgb : r_table[r_active][index_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    r_table[b][e] <= BLACK;
                end
            end
        end else if (wr_en_i && w_wr_ok) begin
            r_table[wr_bank_i][wr_index_i] <= w_wr_rgb;
        end
    end

`ifdef PALETTE_FADE_EN
    logic [3:0] r_bright_stg;
    logic [3:0] r_bright_act;
    logic [3:0] r_bright_d;
    logic       r_valid2;
`endif

    // Staged settings become active only on frame_start; a same-cycle stage bypasses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_staged <= '0;
            r_active <= '0;
`ifdef PALETTE_FADE_EN
            r_bright_stg <= 4'hF;
            r_bright_act <= 4'hF;
`endif
        end else begin
            if (bank_sel_we_i && w_sel_ok) begin
                r_staged <= bank_sel_i;
            end
            if (frame_start_i) begin
                r_active <= (bank_sel_we_i && w_sel_ok) ? bank_sel_i : r_staged;
            end
`ifdef PALETTE_FADE_EN
            if (bank_sel_we_i) begin
                r_bright_stg <= brightness_i;
            end
            if (frame_start_i) begin
                r_bright_act <= bank_sel_we_i ? brightness_i : r_bright_stg;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_rgb   <= BLACK;
`ifdef PALETTE_FADE_EN
            r_bright_d <= 4'hF;
            r_valid2   <= 1'b0;
`endif
        end else begin
            r_valid <= pix_valid_i;
            r_rgb   <= pix_valid_i ? w_lookup : BLACK;
`ifdef PALETTE_FADE_EN
            // Brightness travels with the pixel so a mid-pipeline commit cannot split it.
            r_bright_d <= r_bright_act;
            r_valid2   <= r_valid;
`endif
        end
    end

`ifdef PALETTE_FADE_EN
    palette_fade_scaler #(.COLOR_W(COLOR_W)) u_scale_r (
        .clk(clk), .reset(reset), .c_i(r_rgb.r), .brightness_i(r_bright_d), .c_o(red_o)
    );
    palette_fade_scaler #(.COLOR_W(COLOR_W)) u_scale_g (
        .clk(clk), .reset(reset), .c_i(r_rgb.g), .brightness_i(r_bright_d), .c_o(green_o)
    );
    palette_fade_scaler #(.COLOR_W(COLOR_W)) u_scale_b (
        .clk(clk), .reset(reset), .c_i(r_rgb.b), .brightness_i(r_bright_d), .c_o(blue_o)
    );
    assign pix_valid_o = r_valid2;
`else
    assign red_o       = r_rgb.r;
    assign green_o     = r_rgb.g;
    assign blue_o      = r_rgb.b;
    assign pix_valid_o = r_valid;
`endif

    assign active_bank_o = r_active;

endmodule

`default_nettype wire

// File: tb/tb_banked_palette_lut.sv
// ============================================================================
// Module   : tb_banked_palette_lut
// Purpose  : Directed self-checking bench for banked_palette_lut (PALETTE_FADE_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_banked_palette_lut;

    localparam int INDEX_W   = 4;
    localparam int COLOR_W   = 4;
    localparam int NUM_BANKS = 3;   // non-power-of-two so an out-of-range bank is expressible
    localparam int BANK_W    = 2;
`ifdef PALETTE_FADE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 pix_valid_i;
    logic [INDEX_W-1:0]   index_i;
    logic                 wr_en_i;
    logic [BANK_W-1:0]    wr_bank_i;
    logic [INDEX_W-1:0]   wr_index_i;
    logic [3*COLOR_W-1:0] wr_rgb_i;
    logic                 bank_sel_we_i;
    logic [BANK_W-1:0]    bank_sel_i;
    logic                 frame_start_i;
    logic [3:0]           brightness_i;
    logic                 pix_valid_o;
    logic [COLOR_W-1:0]   red_o;
    logic [COLOR_W-1:0]   green_o;
    logic [COLOR_W-1:0]   blue_o;
    logic [BANK_W-1:0]    active_bank_o;

    int n_pass   = 0;
    int n_checks = 0;

    banked_palette_lut #(
        .INDEX_W(INDEX_W), .COLOR_W(COLOR_W), .NUM_BANKS(NUM_BANKS)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_valid_i(pix_valid_i), .index_i(index_i),
        .wr_en_i(wr_en_i), .wr_bank_i(wr_bank_i), .wr_index_i(wr_index_i), .wr_rgb_i(wr_rgb_i),
        .bank_sel_we_i(bank_sel_we_i), .bank_sel_i(bank_sel_i), .frame_start_i(frame_start_i),
`ifdef PALETTE_FADE_EN
        .brightness_i(brightness_i),
`endif
        .pix_valid_o(pix_valid_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .active_bank_o(active_bank_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] idx, input logic vld);
        pix_valid_i = vld;
        index_i     = idx;
        step();
        pix_valid_i = 1'b0;
        repeat (LAT - 1) step();
    endtask

    task automatic write(input logic [1:0] bank, input logic [3:0] idx, input logic [11:0] rgb);
        wr_en_i    = 1'b1;
        wr_bank_i  = bank;
        wr_index_i = idx;
        wr_rgb_i   = rgb;
        step();
        wr_en_i    = 1'b0;
    endtask

    task automatic stage(input logic [1:0] bank, input logic fs);
        bank_sel_we_i = 1'b1;
        bank_sel_i    = bank;
        frame_start_i = fs;
        step();
        bank_sel_we_i = 1'b0;
        frame_start_i = 1'b0;
    endtask

    logic [11:0] w_rgb;
    assign w_rgb = {red_o, green_o, blue_o};

    initial begin
        reset = 1'b1; pix_valid_i = 1'b0; index_i = '0;
        wr_en_i = 1'b0; wr_bank_i = '0; wr_index_i = '0; wr_rgb_i = '0;
        bank_sel_we_i = 1'b0; bank_sel_i = '0; frame_start_i = 1'b0; brightness_i = 4'hF;
        repeat (2) step();
        chk("reset_valid", 12'(pix_valid_o), 12'h000);
        chk("reset_rgb", w_rgb, 12'h000);
        chk("reset_bank", 12'(active_bank_o), 12'h000);
        reset = 1'b0;

        lookup(4'd5, 1'b1);
        chk("idx5_valid", 12'(pix_valid_o), 12'h001);
        chk("idx5_rgb", w_rgb, 12'h000);

        write(2'd0, 4'd3, 12'hBBB);
        lookup(4'd3, 1'b1);
        chk("idx3_rgb", w_rgb, 12'hBBB);

        lookup(4'd3, 1'b0);
        chk("blank_valid", 12'(pix_valid_o), 12'h000);
        chk("blank_rgb", w_rgb, 12'h000);

        // Write and read the same active entry in one cycle.
        wr_en_i = 1'b1; wr_bank_i = 2'd0; wr_index_i = 4'd7; wr_rgb_i = 12'hA01;
        pix_valid_i = 1'b1; index_i = 4'd7;
        step();
        wr_en_i = 1'b0; pix_valid_i = 1'b0;
        repeat (LAT - 1) step();
        chk("write_first", w_rgb, 12'hA01);

        // Same-cycle write to an inactive bank must not bypass.
        wr_en_i = 1'b1; wr_bank_i = 2'd1; wr_index_i = 4'd7; wr_rgb_i = 12'h333;
        pix_valid_i = 1'b1; index_i = 4'd7;
        step();
        wr_en_i = 1'b0; pix_valid_i = 1'b0;
        repeat (LAT - 1) step();
        chk("no_bypass_other_bank", w_rgb, 12'hA01);

        write(2'd1, 4'd2, 12'h522);
        stage(2'd1, 1'b0);
        lookup(4'd2, 1'b1);
        chk("staged_not_active_rgb", w_rgb, 12'h000);
        chk("staged_not_active_bank", 12'(active_bank_o), 12'h000);

        // Lookup in the frame_start cycle still sees the old bank.
        frame_start_i = 1'b1; pix_valid_i = 1'b1; index_i = 4'd2;
        step();
        frame_start_i = 1'b0; pix_valid_i = 1'b0;
        repeat (LAT - 1) step();
        chk("fs_cycle_old_bank", w_rgb, 12'h000);
        chk("fs_bank_committed", 12'(active_bank_o), 12'h001);
        lookup(4'd2, 1'b1);
        chk("bank1_idx2", w_rgb, 12'h522);

        stage(2'd3, 1'b1);
        chk("bad_stage_ignored", 12'(active_bank_o), 12'h001);
        write(2'd3, 4'd2, 12'hFFF);
        lookup(4'd2, 1'b1);
        chk("bad_write_ignored", w_rgb, 12'h522);

        stage(2'd0, 1'b1);
        chk("direct_commit_bank", 12'(active_bank_o), 12'h000);
        lookup(4'd7, 1'b1);
        chk("bank0_idx7_kept", w_rgb, 12'hA01);

        write(2'd2, 4'd9, 12'hF82);
        brightness_i = 4'd7;
        stage(2'd2, 1'b1);
        brightness_i = 4'hF;
        lookup(4'd9, 1'b1);
`ifdef PALETTE_FADE_EN
        chk("fade_b7", w_rgb, 12'h741);
`else
        chk("bank2_idx9", w_rgb, 12'hF82);
`endif
        chk("bank2_active", 12'(active_bank_o), 12'h002);

        // Reset in the middle of a pixel stream.
        pix_valid_i = 1'b1; index_i = 4'd9;
        repeat (LAT) step();
        chk("stream_valid", 12'(pix_valid_o), 12'h001);
        #2 reset = 1'b1;
        #1;
        chk("midreset_valid", 12'(pix_valid_o), 12'h000);
        chk("midreset_rgb", w_rgb, 12'h000);
        chk("midreset_bank", 12'(active_bank_o), 12'h000);
        pix_valid_i = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_reset_valid", 12'(pix_valid_o), 12'h000);

        lookup(4'd3, 1'b1);
        chk("table_cleared", w_rgb, 12'h000);
        write(2'd0, 4'd9, 12'hF82);
        lookup(4'd9, 1'b1);
        chk("brightness_reset_identity", w_rgb, 12'hF82);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
